string_hw: RTL and testbench
============================

STRING_HW -- requirements
Module: string_hw

Interface
REQ-001 Parameter MAX_BLOCKS, default 2: number of 32-bit blocks per string; N = MAX_BLOCKS*4 characters.
REQ-002 clk  input  1  rising-edge clock; the block SHALL use this single clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 go  input  1  start request, level, held by the host until done is seen.
REQ-005 index  input  4  operation select: 0 compare, 1 to-upper, 2 to-lower, 3 reverse, 4 search.
REQ-006 length  input  8  number of leading characters of B to search for (index 4 only).
REQ-007 A  input  packed [0:N-1][7:0]  operand string; char 0 is the most significant byte; short strings are zero-padded at low indices.
REQ-008 B  input  packed [0:N-1][7:0]  second operand (compare, search pattern).
REQ-009 done  output  1  operation complete; Result valid.
REQ-010 Result  output  packed [0:N-1][7:0]  operation result; numeric results are zero-extended into the full width.

Function
REQ-011 FSM states SHALL be IDLE, RUN, DONE.
REQ-012 IDLE: done=0; when go=1, latch A, B, index and length, clear the work register, and go to RUN.
REQ-013 RUN: process one character position per cycle, k = 0..N-1; go to DONE after position N-1, or earlier for a search hit.
REQ-014 DONE: done=1 and Result stable; stay in DONE while go=1; return to IDLE on the first cycle go=0.
REQ-015 Latency SHALL be at most N+2 cycles from go sampled high to done=1 (10 cycles for N=8).
REQ-016 Result SHALL hold its value from DONE until the next operation's RUN writes it; inputs changing during RUN or DONE SHALL have no effect.
REQ-017 Compare (0): Result = 1 if every byte A[k]==B[k] for k=0..N-1, including padding; else Result = 0.
REQ-018 To-upper (1): Result[k] = A[k]-8'h20 if A[k] is in 'a'..'z'; otherwise Result[k] = A[k].
REQ-019 To-lower (2): Result[k] = A[k]+8'h20 if A[k] is in 'A'..'Z'; otherwise Result[k] = A[k].
REQ-020 Reverse (3): Result[k] = A[N-1-k] for all N bytes, padding included.
REQ-021 Search (4): Result = smallest p such that A[p+j]==B[j] for all j<length; scan p = 0..N-length, one p per cycle.
REQ-022 Search with length=0: Result = 0.
REQ-023 Search with no match, or length>N: Result = all ones.
REQ-024 index values 5..15: Result = 0, done asserted after the normal N-cycle pass.
REQ-025 go held high through DONE SHALL NOT restart the operation; a new operation requires go low for at least one cycle.

Reset
REQ-026 reset=1 SHALL immediately force state IDLE, done=0, Result=0, and clear the latched operands and counters.
REQ-027 reset asserted during RUN or DONE SHALL abort the operation with no partial Result retained.
REQ-028 After reset deasserts, the first go=1 sampled on a clk edge SHALL start an operation.

Structure
REQ-029 Package string_hw_pkg SHALL hold MAX_BLOCKS default, the N constant, the opcode enum (OP_CMP, OP_UPPER, OP_LOWER, OP_REV, OP_SEARCH) and the state enum.
REQ-030 A single sub-module string_hw_case_conv SHALL do the byte case conversion: inputs byte and upper/lower select, output converted byte; string_hw instantiates it once.

Verification
REQ-031 Compare: "abcdefgh" vs "abcadead" -> Result 0; "ab" vs "ac" -> 0; "abcdefgh" vs "abcdefgh" -> 1; "ab" vs "ab" -> 1.
REQ-032 Case: to-upper "AbCdef" -> "ABCDEF" and "ab" -> "AB"; to-lower "ABCDEFGH" -> "abcdefgh" and "Ab" -> "ab"; zero padding SHALL be preserved.
REQ-033 Reverse: "Hello!  " -> "  !olleH"; "  !olleH" -> "Hello!  ".
REQ-034 Search in A="It was I": B="It" with length 2 -> 0; "was" with length 3 -> 3; " I" with length 2 -> 6; "xy" with length 2 -> all ones.
REQ-035 Handshake: done=1 within 10 cycles of go; done stays 1 while go is held; done=0 the cycle after go drops; a back-to-back op after one idle cycle runs correctly.
REQ-036 Reset mid-RUN -> done=0 and Result=0 immediately; the next go completes normally.

Source files
------------

// File: rtl/string_hw_pkg.sv
// Shared constants, opcode/state enums and byte-class helper for the string engine.
package string_hw_pkg;

    localparam int MAX_BLOCKS_DEF = 2;
    localparam int N_DEF          = MAX_BLOCKS_DEF * 4;

    typedef enum logic [3:0] {
        OP_CMP    = 4'd0,
        OP_UPPER  = 4'd1,
        OP_LOWER  = 4'd2,
        OP_REV    = 4'd3,
        OP_SEARCH = 4'd4
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic in_range(input logic [7:0] c, input logic [7:0] lo, input logic [7:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/string_hw_case_conv.sv
// Single-byte ASCII case converter: folds a..z to upper or A..Z to lower, passing all else through.
module string_hw_case_conv
    import string_hw_pkg::*;
(
    input  logic [7:0] in_byte,
    input  logic       to_upper,
    output logic [7:0] out_byte
);

    // Only the letter range of the selected case is shifted by 0x20.
    always_comb begin
        out_byte = in_byte;
        if (to_upper) begin
            if (in_range(in_byte, 8'h61, 8'h7a)) begin
                out_byte = in_byte - 8'h20;
            end else begin
                out_byte = in_byte;
            end
        end else begin
            if (in_range(in_byte, 8'h41, 8'h5a)) begin
                out_byte = in_byte + 8'h20;
            end else begin
                out_byte = in_byte;
            end
        end
    end

endmodule

// File: rtl/string_hw.sv
// Character-serial string engine: compare, case conversion, reverse and substring search,
// one character position per clock behind an IDLE/RUN/DONE handshake.
module string_hw
    import string_hw_pkg::*;
#(
    parameter int MAX_BLOCKS = MAX_BLOCKS_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          go,
    input  logic [3:0]                    index,
    input  logic [7:0]                    length,
    input  logic [0:MAX_BLOCKS*4-1][7:0]  A,
    input  logic [0:MAX_BLOCKS*4-1][7:0]  B,
    output logic                          done,
    output logic [0:MAX_BLOCKS*4-1][7:0]  Result
);

    localparam int N  = MAX_BLOCKS * 4;
    localparam int IW = $clog2(N);

    typedef logic [0:N-1][7:0] str_t;

    state_e     state_q, state_d;
    str_t       a_q, a_d, b_q, b_d, work_q, work_d, res_q, res_d;
    logic [3:0] op_q, op_d;
    logic [7:0] len_q, len_d, k_q, k_d;
    logic       match_q, match_d, done_q, done_d;

    logic [IW-1:0] kidx_s, ridx_s;
    logic [7:0]    conv_in_s, conv_out_s;
    logic          to_upper_s, byte_eq_s, last_s, hit_s;
    str_t          a_sh_s;

    assign kidx_s     = k_q[IW-1:0];
    assign ridx_s     = IW'(N - 1) - kidx_s;
    assign conv_in_s  = a_q[kidx_s];
    assign to_upper_s = (op_q == OP_UPPER);
    assign byte_eq_s  = (a_q[kidx_s] == b_q[kidx_s]);
    assign last_s     = (k_q == 8'(N - 1));
    // Shifting A left by k characters lines candidate position p=k up with B[0].
    assign a_sh_s     = a_q << {k_q, 3'b000};

    string_hw_case_conv u_case_conv (
        .in_byte  (conv_in_s),
        .to_upper (to_upper_s),
        .out_byte (conv_out_s)
    );

    // Search hit at p=k: pattern fits inside A and every pattern byte matches.
    always_comb begin
        hit_s = (len_q <= 8'(N)) && (({1'b0, k_q} + {1'b0, len_q}) <= 9'(N));
        for (int j = 0; j < N; j++) begin
            hit_s = hit_s & ~((8'(j) < len_q) && (a_sh_s[j] != b_q[j]));
        end
    end

    // Next-state, operand latch and per-character datapath.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        len_d   = len_q;
        k_d     = k_q;
        work_d  = work_q;
        match_d = match_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = index;
                    len_d   = length;
                    k_d     = 8'd0;
                    work_d  = '0;
                    match_d = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                case (op_q)
                    OP_CMP:             match_d = match_q & byte_eq_s;
                    OP_UPPER, OP_LOWER: work_d[kidx_s] = conv_out_s;
                    OP_REV:             work_d[kidx_s] = a_q[ridx_s];
                    default:            work_d = work_q;
                endcase
                if ((op_q == OP_SEARCH) && hit_s) begin
                    res_d   = {{(N*8-8){1'b0}}, k_q};
                    state_d = DONE;
                end else if (last_s) begin
                    state_d = DONE;
                    case (op_q)
                        OP_CMP:                     res_d = {{(N*8-1){1'b0}}, match_d};
                        OP_UPPER, OP_LOWER, OP_REV: res_d = work_d;
                        OP_SEARCH:                  res_d = '1;
                        default:                    res_d = '0;
                    endcase
                end else begin
                    k_d = k_q + 8'd1;
                end
            end
            DONE: begin
                // go must fall before another operation can be accepted.
                if (!go) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
    end

    // State, latched operands and result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 4'd0;
            len_q   <= 8'd0;
            k_q     <= 8'd0;
            work_q  <= '0;
            match_q <= 1'b0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            len_q   <= len_d;
            k_q     <= k_d;
            work_q  <= work_d;
            match_q <= match_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign done   = done_q;
    assign Result = res_q;

endmodule

// File: tb/tb_string_hw.sv
// Self-checking bench for string_hw: directed spec vectors plus randomized ops against a string model.
module tb_string_hw;
    import string_hw_pkg::*;

    localparam int N = N_DEF;
    typedef logic [0:N-1][7:0] str_t;

    logic       clk = 1'b0;
    logic       reset, go;
    logic [3:0] index;
    logic [7:0] length;
    str_t       A, B, Result;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    str_t r_res, r_first;
    int   r_lat;
    logic r_seen, r_held, r_after;

    string_hw #(.MAX_BLOCKS(MAX_BLOCKS_DEF)) dut (
        .clk    (clk),
        .reset  (reset),
        .go     (go),
        .index  (index),
        .length (length),
        .A      (A),
        .B      (B),
        .done   (done),
        .Result (Result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic str_t num(input int v);
        str_t r;
        r = '0;
        r[N-1] = 8'(v);
        return r;
    endfunction

    function automatic str_t model(input int op, input str_t a, input str_t b, input int len);
        str_t r;
        bit   found, ok;
        r = '0;
        case (op)
            0: r = (a == b) ? num(1) : num(0);
            1: for (int k = 0; k < N; k++) r[k] = (a[k] >= 8'h61 && a[k] <= 8'h7a) ? a[k] - 8'h20 : a[k];
            2: for (int k = 0; k < N; k++) r[k] = (a[k] >= 8'h41 && a[k] <= 8'h5a) ? a[k] + 8'h20 : a[k];
            3: for (int k = 0; k < N; k++) r[k] = a[N-1-k];
            4: begin
                if (len == 0) r = '0;
                else if (len > N) r = '1;
                else begin
                    r = '1;
                    found = 1'b0;
                    for (int p = 0; p <= N - len; p++) begin
                        ok = 1'b1;
                        for (int j = 0; j < len; j++) if (a[p+j] != b[j]) ok = 1'b0;
                        if (ok && !found) begin
                            found = 1'b1;
                            r = num(p);
                        end
                    end
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Runs one op from a negedge; scrambles inputs after launch, holds go two cycles in DONE, then drops it.
    task automatic run_op(input int op, input str_t a, input str_t b, input int len);
        index = 4'(op); A = a; B = b; length = 8'(len); go = 1'b1;
        @(negedge clk);
        r_lat   = 1;
        r_first = Result;
        A = {$urandom, $urandom}; B = {$urandom, $urandom};
        index = 4'($urandom); length = 8'($urandom);
        while (!done && r_lat < 20) begin
            @(negedge clk);
            r_lat++;
        end
        r_seen = done;
        r_res  = Result;
        @(negedge clk);
        r_held = done && (Result === r_res);
        @(negedge clk);
        r_held = r_held && done && (Result === r_res);
        go = 1'b0;
        @(negedge clk);
        r_after = done;
    endtask

    task automatic test_reset();
        reset = 1'b1; go = 1'b0; index = 4'd0; length = 8'd0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if (Result !== '0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", Result); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_compare();
        str_t ta [4];
        str_t tb [4];
        int   te [4];
        ta = '{"abcdefgh", "ab", "abcdefgh", "ab"};
        tb = '{"abcadead", "ac", "abcdefgh", "ab"};
        te = '{0, 0, 1, 1};
        for (int i = 0; i < 4; i++) begin
            run_op(0, ta[i], tb[i], 0);
            n_checks++;
            if (!r_seen || r_res !== num(te[i])) begin
                n_fail++; $display("FAIL compare[%0d]: Result=%h done=%b expected %h", i, r_res, r_seen, num(te[i]));
            end
        end
    endtask

    task automatic test_case();
        int   top [6];
        str_t ta [6];
        str_t te [6];
        top = '{1, 1, 2, 2, 1, 2};
        ta  = '{"AbCdef", "ab", "ABCDEFGH", "Ab", 64'h405B607B617A415A, 64'h405B607B617A415A};
        te  = '{"ABCDEF", "AB", "abcdefgh", "ab", 64'h405B607B415A415A, 64'h405B607B617A617A};
        for (int i = 0; i < 6; i++) begin
            run_op(top[i], ta[i], '0, 0);
            n_checks++;
            if (!r_seen || r_res !== te[i]) begin
                n_fail++; $display("FAIL case[%0d]: Result=%h expected %h", i, r_res, te[i]);
            end
        end
    endtask

    task automatic test_reverse();
        str_t ta [3];
        str_t te [3];
        ta = '{"Hello!  ", "  !olleH", "ab"};
        te = '{"  !olleH", "Hello!  ", 64'h6261000000000000};
        for (int i = 0; i < 3; i++) begin
            run_op(3, ta[i], '0, 0);
            n_checks++;
            if (!r_seen || r_res !== te[i]) begin
                n_fail++; $display("FAIL reverse[%0d]: Result=%h expected %h", i, r_res, te[i]);
            end
        end
    endtask

    task automatic test_search();
        str_t tp [7];
        int   tpl [7];
        int   tl [7];
        str_t te [7];
        str_t b;
        tp  = '{"It", "was", " I", "xy", "It", "It was I", "It was I"};
        tpl = '{2, 3, 2, 2, 2, 8, 8};
        tl  = '{2, 3, 2, 2, 0, 8, 9};
        te  = '{num(0), num(3), num(6), '1, num(0), num(0), '1};
        for (int i = 0; i < 7; i++) begin
            b = tp[i] << (8 * (N - tpl[i]));
            run_op(4, "It was I", b, tl[i]);
            n_checks++;
            if (!r_seen || r_res !== te[i]) begin
                n_fail++; $display("FAIL search[%0d]: Result=%h expected %h", i, r_res, te[i]);
            end
        end
    endtask

    task automatic test_handshake();
        run_op(3, "12345678", '0, 0);
        n_checks++;
        if (!r_seen || r_lat > N + 2) begin n_fail++; $display("FAIL hs_latency: cycles=%0d expected <= %0d", r_lat, N + 2); end
        n_checks++;
        if (r_held !== 1'b1) begin n_fail++; $display("FAIL hs_hold: held=%b expected 1", r_held); end
        n_checks++;
        if (r_after !== 1'b0) begin n_fail++; $display("FAIL hs_drop: done=%b expected 0", r_after); end
        n_checks++;
        if (r_res !== "87654321") begin n_fail++; $display("FAIL hs_result: Result=%h expected %h", r_res, str_t'("87654321")); end
    endtask

    task automatic test_back_to_back();
        str_t prev;
        run_op(2, "XYZ", '0, 0);
        prev = r_res;
        n_checks++;
        if (prev !== "xyz") begin n_fail++; $display("FAIL b2b_first: Result=%h expected %h", prev, str_t'("xyz")); end
        run_op(1, "qrstuvwx", '0, 0);
        n_checks++;
        if (r_first !== prev) begin n_fail++; $display("FAIL b2b_hold: Result=%h expected %h", r_first, prev); end
        n_checks++;
        if (!r_seen || r_res !== "QRSTUVWX") begin n_fail++; $display("FAIL b2b_second: Result=%h expected %h", r_res, str_t'("QRSTUVWX")); end
    endtask

    task automatic test_random();
        str_t a, b, e;
        int   op, len, p;
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 6);
            for (int k = 0; k < N; k++) begin
                case ($urandom_range(0, 5))
                    0:       a[k] = 8'h00;
                    1, 2:    a[k] = 8'($urandom_range(8'h61, 8'h7a));
                    3:       a[k] = 8'($urandom_range(8'h41, 8'h5a));
                    4:       a[k] = 8'($urandom_range(8'h20, 8'h7e));
                    default: a[k] = 8'($urandom);
                endcase
            end
            b = {$urandom, $urandom};
            len = $urandom_range(0, 9);
            if (op == 0 && $urandom_range(0, 1) == 1) begin
                b = a;
                if ($urandom_range(0, 1) == 1) b[$urandom_range(0, N - 1)] ^= 8'h01;
            end
            if (op == 4 && len <= N && $urandom_range(0, 2) != 0) begin
                p = $urandom_range(0, N - len);
                b = a << (8 * p);
            end
            e = model(op, a, b, len);
            run_op(op, a, b, len);
            n_checks++;
            if (!r_seen || r_res !== e) begin
                n_fail++; $display("FAIL rand[%0d] op=%0d len=%0d: Result=%h expected %h", it, op, len, r_res, e);
            end
            n_checks++;
            if (r_lat > N + 2 || !r_held || r_after !== 1'b0) begin
                n_fail++; $display("FAIL rand_hs[%0d]: cycles=%0d held=%b done_after=%b expected <=%0d,1,0", it, r_lat, r_held, r_after, N + 2);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int waited;
        index = 4'd3; A = "abcdefgh"; B = '0; length = 8'd0; go = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1; go = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0 || Result !== '0) begin n_fail++; $display("FAIL rst_run: done=%b Result=%h expected 0 and 0", done, Result); end
        @(negedge clk);
        reset = 1'b0;
        run_op(1, "mixedCase", '0, 0);
        n_checks++;
        if (!r_seen || r_res !== model(1, "mixedCase", '0, 0)) begin n_fail++; $display("FAIL rst_next: Result=%h", r_res); end
        index = 4'd3; A = "zyxwvuts"; go = 1'b1;
        waited = 0;
        while (!done && waited < 20) begin @(negedge clk); waited++; end
        n_checks++;
        if (done !== 1'b1 || Result !== "stuvwxyz") begin n_fail++; $display("FAIL rst_pre: done=%b Result=%h expected 1 and %h", done, Result, str_t'("stuvwxyz")); end
        reset = 1'b1; go = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0 || Result !== '0) begin n_fail++; $display("FAIL rst_done: done=%b Result=%h expected 0 and 0", done, Result); end
        @(negedge clk);
        reset = 1'b0;
        run_op(0, "same", "same", 0);
        n_checks++;
        if (!r_seen || r_res !== num(1)) begin n_fail++; $display("FAIL rst_after: Result=%h expected %h", r_res, num(1)); end
    endtask

    initial begin
        test_reset();
        test_compare();
        test_case();
        test_reverse();
        test_search();
        test_handshake();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
